// File: rtl/rom_fetch_pkg.sv
// Shared FSM state encoding and default widths for the ROM burst fetcher.
package rom_fetch_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        DRAIN     = 2'd2,
        ERR_FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/rom_fetch_fifo.sv
// Output buffer: power-of-two FIFO with flush, simultaneous push/pop even when full.
module rom_fetch_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      cnt;
    logic             do_wr, do_rd;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign do_rd = rd_en && !empty;
    // A pop frees the slot the push needs, so a full FIFO still accepts.
    assign do_wr = wr_en && (!full || do_rd);
    assign rd_data = mem[rp];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/rom_fetch.sv
// Burst ROM reader: issues credit-limited reads and buffers words with their addresses.
module rom_fetch
    import rom_fetch_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [CNT_W-1:0]  count_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              rom_en_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    input  logic              rom_error_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_addr_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr, pend_addr;
    logic [CNT_W-1:0]  left;
    logic              pend, err, zero_done, drain_done;
    logic              accept, active, credit, issue, ret_ok, ret_err, flush, pop;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty;
    logic [ADDR_W+DATA_W-1:0] fifo_rd;

    assign accept  = start_i && (state == IDLE);
    assign active  = (state == ISSUE) || (state == DRAIN);
    assign ret_err = pend && rom_error_i && active;
    assign ret_ok  = pend && !rom_error_i && active;
    // Credit counts the word still in flight so a full FIFO can never be overrun.
    assign credit  = (32'(fifo_count) + 32'(pend)) < FIFO_DEPTH;
    assign issue   = (state == ISSUE) && credit && !ret_err;
    assign flush   = ret_err || (state == ERR_FLUSH);
    assign pop     = out_valid_o && out_ready_i;

    assign busy_o      = (state != IDLE);
    assign err_o       = err;
    assign rom_en_o    = issue;
    assign rom_addr_o  = addr;
    assign out_valid_o = !fifo_empty && (state != ERR_FLUSH);
    assign out_addr_o  = fifo_rd[ADDR_W+DATA_W-1:DATA_W];
    assign out_data_o  = fifo_rd[DATA_W-1:0];
    assign done_o      = drain_done || (state == ERR_FLUSH) || zero_done;

    always_comb begin
        state_nx   = state;
        drain_done = 1'b0;
        case (state)
            IDLE:      if (start_i && count_i != '0) state_nx = ISSUE;
            ISSUE: begin
                if (ret_err)                        state_nx = ERR_FLUSH;
                else if (issue && left == CNT_W'(1)) state_nx = DRAIN;
            end
            DRAIN: begin
                if (ret_err) state_nx = ERR_FLUSH;
                else if (fifo_empty && !pend) begin
                    state_nx   = IDLE;
                    drain_done = 1'b1;
                end
            end
            ERR_FLUSH: state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            pend_addr <= '0;
            left      <= '0;
            pend      <= 1'b0;
            err       <= 1'b0;
            zero_done <= 1'b0;
        end else begin
            state     <= state_nx;
            pend      <= issue;
            zero_done <= accept && (count_i == '0);
            if (accept) begin
                addr <= start_addr_i;
                left <= count_i;
                err  <= 1'b0;
            end
            if (issue) begin
                addr      <= addr + 1'b1;
                left      <= left - 1'b1;
                pend_addr <= addr;
            end
            if (ret_err) err <= 1'b1;
        end
    end

    rom_fetch_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (ret_ok),
        .wr_data ({pend_addr, rom_data_i}),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_rom_fetch.sv
// Directed bench for rom_fetch; ROM model returns {8'hA5, addr} one cycle after each read.
module tb_rom_fetch;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  start_addr_i = '0, count_i = '0;
    logic        busy_o, done_o, err_o, rom_en_o;
    logic [7:0]  rom_addr_o, out_addr_o;
    logic [15:0] rom_data_i = '0, out_data_o;
    logic        rom_error_i = 1'b0;
    logic        out_valid_o, out_ready_i = 1'b0;

    rom_fetch dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .start_addr_i(start_addr_i),
        .count_i(count_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .rom_error_i(rom_error_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_addr_o(out_addr_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM model with error injection on the err_at-th read of the current burst
    int n_ret = 0, err_base = 0, err_at = 0;
    always @(posedge clk) begin
        if (rom_en_o) begin
            rom_data_i  <= {8'hA5, rom_addr_o};
            rom_error_i <= (err_at != 0) && (n_ret + 1 - err_base == err_at);
            n_ret       <= n_ret + 1;
        end else begin
            rom_data_i  <= 16'hDEAD;
            rom_error_i <= 1'b0;
        end
    end

    logic [7:0]  rd_addr_q[$];
    int          rd_cyc_q[$];
    logic [7:0]  oa_q[$];
    logic [15:0] od_q[$];
    int          done_cnt = 0, done_cyc = 0;

    always @(negedge clk) begin
        if (rom_en_o) begin
            rd_addr_q.push_back(rom_addr_o);
            rd_cyc_q.push_back(cyc);
        end
        if (out_valid_o && out_ready_i) begin
            oa_q.push_back(out_addr_o);
            od_q.push_back(out_data_o);
        end
        if (done_o) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    int errors = 0, checks = 0;
    int rb = 0, ob = 0, db = 0, s = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [7:0] a, input logic [7:0] c);
        rb = rd_addr_q.size();
        ob = oa_q.size();
        db = done_cnt;
        err_base = n_ret;
        start_addr_i = a;
        count_i = c;
        start_i = 1'b1;
        s = cyc;
        tick(1);
        start_i = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == db && n < 100) begin
            tick(1);
            n++;
        end
        tick(3);
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] a0, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] ea;
            ea = a0 + 8'(i);
            if (ob + i < oa_q.size()) begin
                chk({tag, "_addr"}, 32'(oa_q[ob+i]), 32'(ea));
                chk({tag, "_data"}, 32'(od_q[ob+i]), 32'({8'hA5, ea}));
            end
        end
    endtask

    initial begin
        logic [15:0] hold_d;
        logic [7:0]  hold_a;

        // reset state
        tick(2);
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_done", 32'(done_o), 32'(0));
        chk("rst_err", 32'(err_o), 32'(0));
        chk("rst_rom_en", 32'(rom_en_o), 32'(0));
        chk("rst_valid", 32'(out_valid_o), 32'(0));
        chk("rst_addr", 32'(rom_addr_o), 32'(0));
        rst_n = 1'b1;
        tick(2);

        // basic burst 0x10 x3, consumer always ready
        out_ready_i = 1'b1;
        start_burst(8'h10, 8'd3);
        wait_done();
        chk("t1_reads", 32'(rd_addr_q.size() - rb), 32'(3));
        chk("t1_rd0", 32'(rd_addr_q[rb]), 32'h10);
        chk("t1_rd2", 32'(rd_addr_q[rb+2]), 32'h12);
        chk("t1_first_cyc", 32'(rd_cyc_q[rb]), 32'(s + 1));
        chk("t1_last_cyc", 32'(rd_cyc_q[rb+2]), 32'(s + 3));
        chk("t1_nout", 32'(oa_q.size() - ob), 32'(3));
        chk_outs("t1", 8'h10, 3);
        chk("t1_done", 32'(done_cnt - db), 32'(1));
        chk("t1_err", 32'(err_o), 32'(0));
        chk("t1_busy", 32'(busy_o), 32'(0));

        // address wrap
        start_burst(8'hFE, 8'd4);
        wait_done();
        chk("t2_nout", 32'(oa_q.size() - ob), 32'(4));
        chk_outs("t2", 8'hFE, 4);
        chk("t2_done", 32'(done_cnt - db), 32'(1));

        // backpressure: credit limits reads to FIFO depth
        out_ready_i = 1'b0;
        start_burst(8'h50, 8'd8);
        tick(12);
        chk("t3_reads_stall", 32'(rd_addr_q.size() - rb), 32'(4));
        chk("t3_valid", 32'(out_valid_o), 32'(1));
        hold_d = out_data_o;
        hold_a = out_addr_o;
        tick(3);
        chk("t3_hold_addr", 32'(out_addr_o), 32'(hold_a));
        chk("t3_hold_data", 32'(out_data_o), 32'(hold_d));
        chk("t3_head_addr", 32'(out_addr_o), 32'h50);
        out_ready_i = 1'b1;
        wait_done();
        chk("t3_reads", 32'(rd_addr_q.size() - rb), 32'(8));
        chk("t3_nout", 32'(oa_q.size() - ob), 32'(8));
        chk_outs("t3", 8'h50, 8);
        chk("t3_done", 32'(done_cnt - db), 32'(1));

        // ROM error on 3rd return with words buffered
        out_ready_i = 1'b0;
        err_at = 3;
        start_burst(8'h60, 8'd6);
        wait_done();
        err_at = 0;
        chk("t4_no5th", 32'(rd_addr_q.size() - rb < 5), 32'(1));
        chk("t4_err", 32'(err_o), 32'(1));
        chk("t4_valid", 32'(out_valid_o), 32'(0));
        chk("t4_done", 32'(done_cnt - db), 32'(1));
        chk("t4_busy", 32'(busy_o), 32'(0));
        out_ready_i = 1'b1;
        tick(3);
        chk("t4_flushed", 32'(oa_q.size() - ob), 32'(0));

        // empty burst: done next cycle, no reads, error cleared
        start_burst(8'h70, 8'd0);
        tick(3);
        chk("t5_done", 32'(done_cnt - db), 32'(1));
        chk("t5_done_cyc", 32'(done_cyc), 32'(s + 1));
        chk("t5_reads", 32'(rd_addr_q.size() - rb), 32'(0));
        chk("t5_err", 32'(err_o), 32'(0));
        chk("t5_busy", 32'(busy_o), 32'(0));

        // start while busy is ignored
        start_burst(8'h40, 8'd3);
        start_addr_i = 8'h80;
        count_i = 8'd5;
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        wait_done();
        chk("t6_reads", 32'(rd_addr_q.size() - rb), 32'(3));
        chk("t6_nout", 32'(oa_q.size() - ob), 32'(3));
        chk_outs("t6", 8'h40, 3);
        chk("t6_done", 32'(done_cnt - db), 32'(1));

        // reset mid-burst, then a clean burst
        out_ready_i = 1'b0;
        start_burst(8'h20, 8'd8);
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("t7_busy", 32'(busy_o), 32'(0));
        chk("t7_done", 32'(done_o), 32'(0));
        chk("t7_rom_en", 32'(rom_en_o), 32'(0));
        chk("t7_valid", 32'(out_valid_o), 32'(0));
        chk("t7_addr", 32'(rom_addr_o), 32'(0));
        chk("t7_err", 32'(err_o), 32'(0));
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("t7_no_done", 32'(done_cnt - db), 32'(0));
        chk("t7_empty", 32'(out_valid_o), 32'(0));
        out_ready_i = 1'b1;
        start_burst(8'h30, 8'd2);
        wait_done();
        chk("t7_nout", 32'(oa_q.size() - ob), 32'(2));
        chk_outs("t7", 8'h30, 2);
        chk("t7_done2", 32'(done_cnt - db), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_fetch.md
ROM_FETCH -- requirements
Module: rom_fetch

Interface
REQ-001 Parameter DATA_W, default 16, ROM data word width.
REQ-002 Parameter ADDR_W, default 8, ROM address width.
REQ-003 Parameter CNT_W, default 8, burst length counter width.
REQ-004 Parameter FIFO_DEPTH, default 4, output buffer depth (power of two, at least 2).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start_i  input  1  one-cycle burst request.
REQ-008 start_addr_i  input  ADDR_W  first ROM address of the burst.
REQ-009 count_i  input  CNT_W  number of words to fetch; 0 means an empty burst.
REQ-010 busy_o  output  1  burst in progress.
REQ-011 done_o  output  1  one-cycle pulse at burst end (normal or error).
REQ-012 err_o  output  1  sticky error flag for the last burst.
REQ-013 rom_en_o  output  1  ROM read strobe.
REQ-014 rom_addr_o  output  ADDR_W  ROM address.
REQ-015 rom_data_i  input  DATA_W  ROM data, valid one cycle after rom_en_o.
REQ-016 rom_error_i  input  1  ROM error, qualified with rom_data_i.
REQ-017 out_valid_o  output  1  output word available.
REQ-018 out_ready_i  input  1  consumer accepts the word.
REQ-019 out_data_o  output  DATA_W  fetched word.
REQ-020 out_addr_o  output  ADDR_W  address the word was fetched from.

Function
REQ-021 FSM states: IDLE, ISSUE, DRAIN, ERR_FLUSH.
- IDLE -> ISSUE on start_i when count_i is nonzero.
- ISSUE -> DRAIN after the last read is issued.
- DRAIN -> IDLE once the FIFO is empty and no read is in flight.
- Any busy state -> ERR_FLUSH on rom_error_i.
- ERR_FLUSH -> IDLE after one cycle.
REQ-022 start_i in IDLE with count_i equal to 0 shall cause done_o to pulse in the next cycle, issue no ROM reads and leave err_o at 0.
REQ-023 start_i shall be ignored while busy_o is 1.
REQ-024 Accepting a start shall clear err_o and latch start_addr_i and count_i.
REQ-025 In ISSUE, rom_en_o shall assert only when FIFO occupancy plus in-flight reads is less than FIFO_DEPTH.
- The first rom_en_o occurs in the cycle after start acceptance.
- Back-to-back reads at one per cycle are allowed while credit is available.
REQ-026 rom_addr_o shall increment by 1 per issued read and wrap modulo 2^ADDR_W (0xFF -> 0x00).
REQ-027 Each returned word shall be written to the FIFO together with its address, one cycle after its rom_en_o, in issue order.
REQ-028 The output port shall be a valid/ready port.
- A transfer occurs when out_valid_o and out_ready_i are both 1.
- out_data_o and out_addr_o shall hold stable while out_valid_o is 1 and out_ready_i is 0.
REQ-029 A FIFO write and a FIFO read in the same cycle shall both occur, including when the FIFO is full.
REQ-030 On rom_error_i:
- the returning word is discarded;
- no further reads are issued;
- the FIFO is flushed;
- err_o is set;
- done_o pulses as the FSM leaves ERR_FLUSH.
REQ-031 A read still in flight when rom_error_i arrives shall return in ERR_FLUSH and be discarded.
REQ-032 On normal completion, done_o shall pulse in the cycle the FSM moves from DRAIN to IDLE.
REQ-033 busy_o shall be 1 in every state except IDLE.

Reset
REQ-034 While rst_n is 0, the block shall be in the following state:
- FSM in IDLE;
- busy_o, done_o, err_o, rom_en_o and out_valid_o at 0;
- rom_addr_o at 0;
- FIFO empty;
- counters and the in-flight count at 0.
REQ-035 Reset asserted mid-burst shall abort the burst immediately, without a done_o pulse, and discard all buffered data.

Structure
REQ-036 A shared package rom_fetch_pkg shall hold the FSM state enum and the default width constants.
REQ-037 The output buffer shall be a separate sub-module, rom_fetch_fifo, with parameters for width and depth, full/empty flags and a count.

Verification
REQ-038 start_addr 0x10, count 3, out_ready held at 1:
- reads 0x10, 0x11, 0x12 on consecutive cycles;
- three outputs in order;
- done_o pulses once;
- err_o stays 0.
REQ-039 start_addr 0xFE, count 4: out_addr shall be 0xFE, 0xFF, 0x00, 0x01.
REQ-040 count 8, out_ready held at 0: after 4 reads, rom_en_o shall stop; raising out_ready shall deliver all 8 words with no loss or duplication.
REQ-041 count 6, rom_error_i on the 3rd return:
- no 5th read is issued;
- out_valid_o drops;
- err_o is 1;
- done_o pulses once.
REQ-042 count 0 start yields a done_o pulse one cycle later with no rom_en_o; start_i while busy is ignored.
REQ-043 rst_n pulled low mid-burst: all outputs return to their reset values at once; a new burst then runs correctly.
